// File: rtl/wiv_amo_sequencer.sv
// RV64A atomic sequencer for the WivCPU MEM stage: LR/SC and AMO read-modify-write.
// Optional LR/SC support and the reservation logic are enabled by defining WIV_AMO_LRSC_EN.
//
// state | meaning
// IDLE  | ready for a new atomic request
// READ  | bus read in progress (LR, AMO)
// WRITE | bus write in progress (SC success, AMO)
// RESP  | one-cycle result strobe to writeback
module wiv_amo_sequencer #(
   parameter int RSV_GRAN_BITS = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [4:0]  req_funct5_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [63:0] req_addr_i,
   input  logic [63:0] req_data_i,
   output logic        rsp_valid_o,
   output logic [63:0] rsp_data_o,
   output logic        rsp_misaligned_o,
   output logic        rsp_fault_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   output logic [7:0]  mem_sel_o,
   input  logic        mem_ack_i,
   input  logic        mem_err_i,
   input  logic [63:0] mem_rdata_i,
   input  logic        snoop_valid_i,
   input  logic [63:0] snoop_addr_i,
   input  logic        kill_i
);

   typedef enum logic [4:0] {
      AMO_ADD  = 5'b00000,
      AMO_SWAP = 5'b00001,
      AMO_LR   = 5'b00010,
      AMO_SC   = 5'b00011,
      AMO_XOR  = 5'b00100,
      AMO_OR   = 5'b01000,
      AMO_AND  = 5'b01100,
      AMO_MIN  = 5'b10000,
      AMO_MAX  = 5'b10100,
      AMO_MINU = 5'b11000,
      AMO_MAXU = 5'b11100
   } funct5_amo_type_t;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

   state_t           state_q, state_d;
   funct5_amo_type_t op_q, op_d, req_op;
   logic             word_q, word_d;
   logic [63:0]      addr_q, addr_d;
   logic [63:0]      opnd_q, opnd_d;
   logic [63:0]      wdata_q, wdata_d;
   logic [63:0]      rsp_data_q, rsp_data_d;
   logic             mis_q, mis_d;
   logic             fault_q, fault_d;

   logic        accept, req_word, width_ok, misaligned, f5_ok;
   logic [31:0] lane_rd;
   logic [63:0] old_val, opnd_ext, amo_res, wr_val;
   logic        lt_s, lt_u;

   assign req_op      = funct5_amo_type_t'(req_funct5_i);
   assign req_ready_o = (state_q == S_IDLE) & ~rst_i;
   assign accept      = req_valid_i & req_ready_o;
   assign req_word    = (req_funct3_i == 3'h2);
   assign width_ok    = (req_funct3_i == 3'h2) | (req_funct3_i == 3'h3);
   assign misaligned  = ((req_funct3_i == 3'h2) & (req_addr_i[1:0] != 2'b00)) |
                        ((req_funct3_i == 3'h3) & (req_addr_i[2:0] != 3'b000));

   always_comb begin
      f5_ok = 1'b0;
      case (req_op)
         AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
         AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: f5_ok = 1'b1;
`ifdef WIV_AMO_LRSC_EN
         AMO_LR, AMO_SC: f5_ok = 1'b1;
`endif
         default: f5_ok = 1'b0;
      endcase
   end

   // Word ops are evaluated on sign-extended operands; this keeps signed and
   // unsigned ordering of the 32-bit values and the low half of the sum exact.
   assign lane_rd  = addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
   assign old_val  = word_q ? {{32{lane_rd[31]}}, lane_rd} : mem_rdata_i;
   assign opnd_ext = word_q ? {{32{opnd_q[31]}}, opnd_q[31:0]} : opnd_q;
   assign lt_s     = $signed(old_val) < $signed(opnd_ext);
   assign lt_u     = old_val < opnd_ext;

   always_comb begin
      amo_res = opnd_ext;
      case (op_q)
         AMO_ADD:  amo_res = old_val + opnd_ext;
         AMO_XOR:  amo_res = old_val ^ opnd_ext;
         AMO_OR:   amo_res = old_val | opnd_ext;
         AMO_AND:  amo_res = old_val & opnd_ext;
         AMO_MIN:  amo_res = lt_s ? old_val : opnd_ext;
         AMO_MAX:  amo_res = lt_s ? opnd_ext : old_val;
         AMO_MINU: amo_res = lt_u ? old_val : opnd_ext;
         AMO_MAXU: amo_res = lt_u ? opnd_ext : old_val;
         default:  amo_res = opnd_ext;
      endcase
   end

   assign wr_val = word_q ? {amo_res[31:0], amo_res[31:0]} : amo_res;

`ifdef WIV_AMO_LRSC_EN
   logic                     rsv_valid_q, rsv_valid_d;
   logic [63:RSV_GRAN_BITS]  rsv_addr_q, rsv_addr_d;
   logic                     rsv_hit;
   logic                     unused_gran;
   assign rsv_hit     = rsv_valid_q & (rsv_addr_q == req_addr_i[63:RSV_GRAN_BITS]);
   assign unused_gran = ^snoop_addr_i[RSV_GRAN_BITS-1:0];
`else
   logic unused_lrsc;
   assign unused_lrsc = ^{snoop_valid_i, kill_i, snoop_addr_i[63:RSV_GRAN_BITS],
                          snoop_addr_i[RSV_GRAN_BITS-1:0]};
`endif

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      word_d     = word_q;
      addr_d     = addr_q;
      opnd_d     = opnd_q;
      wdata_d    = wdata_q;
      rsp_data_d = rsp_data_q;
      mis_d      = mis_q;
      fault_d    = fault_q;
`ifdef WIV_AMO_LRSC_EN
      rsv_valid_d = rsv_valid_q;
      rsv_addr_d  = rsv_addr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d       = req_op;
               word_d     = req_word;
               addr_d     = req_addr_i;
               opnd_d     = req_data_i;
               wdata_d    = req_word ? {req_data_i[31:0], req_data_i[31:0]} : req_data_i;
               mis_d      = 1'b0;
               fault_d    = 1'b0;
               rsp_data_d = 64'd0;
               state_d    = S_RESP;
               if (misaligned) mis_d = 1'b1;
               else if (!width_ok || !f5_ok) fault_d = 1'b1;
`ifdef WIV_AMO_LRSC_EN
               else if (req_op == AMO_SC) begin
                  rsv_valid_d = 1'b0;
                  if (rsv_hit) state_d = S_WRITE;
                  else rsp_data_d = 64'd1;
               end
`endif
               else state_d = S_READ;
            end
         end
         S_READ: begin
            if (mem_err_i) begin
               fault_d    = 1'b1;
               rsp_data_d = 64'd0;
               state_d    = S_RESP;
            end else if (mem_ack_i) begin
               rsp_data_d = old_val;
`ifdef WIV_AMO_LRSC_EN
               if (op_q == AMO_LR) begin
                  rsv_valid_d = 1'b1;
                  rsv_addr_d  = addr_q[63:RSV_GRAN_BITS];
                  state_d     = S_RESP;
               end else
`endif
               begin
                  wdata_d = wr_val;
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (mem_err_i) begin
               fault_d    = 1'b1;
               rsp_data_d = 64'd0;
               state_d    = S_RESP;
            end else if (mem_ack_i) begin
               state_d = S_RESP;
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef WIV_AMO_LRSC_EN
      // Compared against the next-state address so a snoop in the LR ack cycle wins.
      if (kill_i || (snoop_valid_i && (snoop_addr_i[63:RSV_GRAN_BITS] == rsv_addr_d)))
         rsv_valid_d = 1'b0;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         op_q       <= AMO_ADD;
         word_q     <= 1'b0;
         addr_q     <= 64'd0;
         opnd_q     <= 64'd0;
         wdata_q    <= 64'd0;
         rsp_data_q <= 64'd0;
         mis_q      <= 1'b0;
         fault_q    <= 1'b0;
`ifdef WIV_AMO_LRSC_EN
         rsv_valid_q <= 1'b0;
         rsv_addr_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         opnd_q     <= opnd_d;
         wdata_q    <= wdata_d;
         rsp_data_q <= rsp_data_d;
         mis_q      <= mis_d;
         fault_q    <= fault_d;
`ifdef WIV_AMO_LRSC_EN
         rsv_valid_q <= rsv_valid_d;
         rsv_addr_q  <= rsv_addr_d;
`endif
      end
   end

   assign mem_req_o        = (state_q == S_READ) | (state_q == S_WRITE);
   assign mem_we_o         = (state_q == S_WRITE);
   assign mem_addr_o       = {addr_q[63:3], 3'b000};
   assign mem_wdata_o      = wdata_q;
   assign mem_sel_o        = !mem_req_o ? 8'h00 :
                             !word_q    ? 8'hFF :
                             addr_q[2]  ? 8'hF0 : 8'h0F;
   assign rsp_valid_o      = (state_q == S_RESP);
   assign rsp_data_o       = rsp_data_q;
   assign rsp_misaligned_o = rsp_valid_o & mis_q;
   assign rsp_fault_o      = rsp_valid_o & fault_q;

endmodule

// File: tb/tb_wiv_amo_sequencer.sv
// Directed self-checking bench for wiv_amo_sequencer with a single-cycle-ack memory model.
// LR/SC scenarios run when WIV_AMO_LRSC_EN is defined; otherwise LR must fault.
module tb_wiv_amo_sequencer;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [4:0]  req_funct5_i = 5'd0;
   logic [2:0]  req_funct3_i = 3'd0;
   logic [63:0] req_addr_i = 64'd0;
   logic [63:0] req_data_i = 64'd0;
   logic        rsp_valid_o;
   logic [63:0] rsp_data_o;
   logic        rsp_misaligned_o;
   logic        rsp_fault_o;
   logic        mem_req_o, mem_we_o;
   logic [63:0] mem_addr_o, mem_wdata_o;
   logic [7:0]  mem_sel_o;
   logic        mem_ack_i, mem_err_i;
   logic [63:0] mem_rdata_i;
   logic        snoop_valid_i = 1'b0;
   logic [63:0] snoop_addr_i = 64'd0;
   logic        kill_i = 1'b0;

   always #5 clk_i = ~clk_i;

   wiv_amo_sequencer #(.RSV_GRAN_BITS(3)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_funct5_i(req_funct5_i), .req_funct3_i(req_funct3_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
      .rsp_misaligned_o(rsp_misaligned_o), .rsp_fault_o(rsp_fault_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o),
      .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
      .snoop_valid_i(snoop_valid_i), .snoop_addr_i(snoop_addr_i), .kill_i(kill_i)
   );

   logic [63:0] mem [0:2047];
   logic        err_rd = 1'b0;
   logic        stall_wr = 1'b0;

   assign mem_rdata_i = mem[mem_addr_o[13:3]];
   assign mem_err_i   = mem_req_o & ~mem_we_o & err_rd;
   assign mem_ack_i   = mem_req_o & ~mem_err_i & ~(mem_we_o & stall_wr);

   int          cyc = 0, n_wr = 0, n_req = 0, n_rsp = 0;
   logic [63:0] wr_addr = 64'd0, wr_data = 64'd0;
   logic [7:0]  wr_sel = 8'd0;

   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      if (mem_req_o) n_req <= n_req + 1;
      if (rsp_valid_o) n_rsp <= n_rsp + 1;
      if (mem_req_o && mem_we_o && mem_ack_i) begin
         n_wr    <= n_wr + 1;
         wr_addr <= mem_addr_o;
         wr_data <= mem_wdata_o;
         wr_sel  <= mem_sel_o;
      end
   end

   int          checks = 0, errors = 0;
   logic [63:0] r_data;
   logic        r_mis, r_fault;
   int          r_lat;
   int          w0, q0, p0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one request and captures the response; optional snoop in the cycle after acceptance.
   task automatic issue(input logic [4:0] f5, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] d, input logic sn, input logic [63:0] sn_addr);
      int  t0, k;
      logic got;
      @(negedge clk_i);
      req_valid_i = 1'b1; req_funct5_i = f5; req_funct3_i = f3;
      req_addr_i = a; req_data_i = d;
      k = 0;
      while (!req_ready_o && k < 20) begin @(negedge clk_i); k++; end
      t0 = cyc;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      if (sn) begin
         snoop_valid_i = 1'b1; snoop_addr_i = sn_addr;
         @(posedge clk_i); #1;
         snoop_valid_i = 1'b0;
      end
      got = 1'b0; k = 0;
      while (!got && k < 20) begin
         @(negedge clk_i);
         if (rsp_valid_o) got = 1'b1; else k++;
      end
      chk("rsp_seen", {63'd0, got}, 64'd1);
      r_lat = cyc - t0; r_data = rsp_data_o; r_mis = rsp_misaligned_o; r_fault = rsp_fault_o;
      @(negedge clk_i);
      chk("rsp_one_cycle", {63'd0, rsp_valid_o}, 64'd0);
   endtask

   task automatic pulse_snoop(input logic [63:0] a);
      @(negedge clk_i); snoop_valid_i = 1'b1; snoop_addr_i = a;
      @(negedge clk_i); snoop_valid_i = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 64'd0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_ready", {63'd0, req_ready_o}, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
      chk("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
      chk("rst_mem_we", {63'd0, mem_we_o}, 64'd0);
      chk("rst_sel", {56'd0, mem_sel_o}, 64'd0);
      chk("rst_rsp_data", rsp_data_o, 64'd0);
      chk("rst_mem_addr", mem_addr_o, 64'd0);
      chk("rst_mem_wdata", mem_wdata_o, 64'd0);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("ready_idle", {63'd0, req_ready_o}, 64'd1);

      // AMOADD.D
      mem[11'h200] = 64'h5; w0 = n_wr;
      issue(5'h00, 3'h3, 64'h1000, 64'h3, 1'b0, 64'd0);
      chk("add_d_lat", r_lat, 3);
      chk("add_d_rd", r_data, 64'h5);
      chk("add_d_flags", {62'd0, r_mis, r_fault}, 64'd0);
      chk("add_d_nwr", n_wr - w0, 1);
      chk("add_d_wdata", wr_data, 64'h8);
      chk("add_d_sel", {56'd0, wr_sel}, 64'hFF);
      chk("add_d_waddr", wr_addr, 64'h1000);

      // AMOMIN.W upper lane
      mem[11'h200] = 64'h80000000_00000000;
      issue(5'h10, 3'h2, 64'h1004, 64'h1, 1'b0, 64'd0);
      chk("min_w_rd", r_data, 64'hFFFFFFFF_80000000);
      chk("min_w_wdata", wr_data, 64'h80000000_80000000);
      chk("min_w_sel", {56'd0, wr_sel}, 64'hF0);
      chk("min_w_waddr", wr_addr, 64'h1000);

      // AMOMAXU.W lower lane
      mem[11'h300] = 64'h00000000_FFFFFFFE;
      issue(5'h1C, 3'h2, 64'h1800, 64'h5, 1'b0, 64'd0);
      chk("maxu_w_rd", r_data, 64'hFFFFFFFF_FFFFFFFE);
      chk("maxu_w_wdata", wr_data, 64'hFFFFFFFE_FFFFFFFE);
      chk("maxu_w_sel", {56'd0, wr_sel}, 64'h0F);

      // AMOMAX.D signed: -1 vs 2
      mem[11'h301] = 64'hFFFFFFFF_FFFFFFFF;
      issue(5'h14, 3'h3, 64'h1808, 64'h2, 1'b0, 64'd0);
      chk("max_d_rd", r_data, 64'hFFFFFFFF_FFFFFFFF);
      chk("max_d_wdata", wr_data, 64'h2);

      // AMOADD.W 32-bit wrap in upper lane
      mem[11'h302] = 64'h7FFFFFFF_00000000;
      issue(5'h00, 3'h2, 64'h1814, 64'h1, 1'b0, 64'd0);
      chk("add_w_rd", r_data, 64'h00000000_7FFFFFFF);
      chk("add_w_wdata", wr_data, 64'h80000000_80000000);

      // AMOXOR.D, AMOAND.W, AMOSWAP.D
      mem[11'h303] = 64'hF0F0;
      issue(5'h04, 3'h3, 64'h1818, 64'hFF, 1'b0, 64'd0);
      chk("xor_d_rd", r_data, 64'hF0F0);
      chk("xor_d_wdata", wr_data, 64'hF00F);
      mem[11'h304] = 64'hDEADBEEF_0000FFFF;
      issue(5'h0C, 3'h2, 64'h1820, 64'h12345678, 1'b0, 64'd0);
      chk("and_w_rd", r_data, 64'h0000FFFF);
      chk("and_w_wdata", wr_data, 64'h00005678_00005678);
      mem[11'h305] = 64'h11;
      issue(5'h01, 3'h3, 64'h1828, 64'h22, 1'b0, 64'd0);
      chk("swap_d_rd", r_data, 64'h11);
      chk("swap_d_wdata", wr_data, 64'h22);

      // Misaligned and illegal requests: no bus access
      q0 = n_req;
      issue(5'h01, 3'h2, 64'h3002, 64'h0, 1'b0, 64'd0);
      chk("mis_w_lat", r_lat, 1);
      chk("mis_w_flags", {62'd0, r_mis, r_fault}, 64'b10);
      issue(5'h00, 3'h3, 64'h1004, 64'h0, 1'b0, 64'd0);
      chk("mis_d_flags", {62'd0, r_mis, r_fault}, 64'b10);
      issue(5'h05, 3'h3, 64'h1001, 64'h0, 1'b0, 64'd0);
      chk("mis_prio_flags", {62'd0, r_mis, r_fault}, 64'b10);
      issue(5'h00, 3'h1, 64'h1000, 64'h0, 1'b0, 64'd0);
      chk("bad_f3_flags", {62'd0, r_mis, r_fault}, 64'b01);
      chk("bad_f3_lat", r_lat, 1);
      issue(5'h05, 3'h3, 64'h1000, 64'h0, 1'b0, 64'd0);
      chk("bad_f5_flags", {62'd0, r_mis, r_fault}, 64'b01);
      chk("no_bus_req", n_req - q0, 0);

      // AMOOR.D with a read error
      err_rd = 1'b1; w0 = n_wr;
      mem[11'h306] = 64'h1234;
      issue(5'h08, 3'h3, 64'h1830, 64'h1, 1'b0, 64'd0);
      err_rd = 1'b0;
      chk("err_flags", {62'd0, r_mis, r_fault}, 64'b01);
      chk("err_rd", r_data, 64'd0);
      chk("err_lat", r_lat, 2);
      chk("err_no_write", n_wr - w0, 0);

`ifdef WIV_AMO_LRSC_EN
      // LR.D then SC.D succeeds; repeated SC fails
      mem[11'h400] = 64'h12345678;
      issue(5'h02, 3'h3, 64'h2000, 64'h0, 1'b0, 64'd0);
      chk("lr_d_rd", r_data, 64'h12345678);
      chk("lr_d_lat", r_lat, 2);
      w0 = n_wr;
      issue(5'h03, 3'h3, 64'h2000, 64'hAB, 1'b0, 64'd0);
      chk("sc_ok_rd", r_data, 64'd0);
      chk("sc_ok_lat", r_lat, 2);
      chk("sc_ok_nwr", n_wr - w0, 1);
      chk("sc_ok_wdata", wr_data, 64'hAB);
      chk("sc_ok_sel", {56'd0, wr_sel}, 64'hFF);
      w0 = n_wr;
      issue(5'h03, 3'h3, 64'h2000, 64'hCD, 1'b0, 64'd0);
      chk("sc_again_rd", r_data, 64'd1);
      chk("sc_again_lat", r_lat, 1);
      chk("sc_again_nwr", n_wr - w0, 0);

      // Snoop in the same granule kills the reservation
      issue(5'h02, 3'h3, 64'h2000, 64'h0, 1'b0, 64'd0);
      pulse_snoop(64'h2004);
      issue(5'h03, 3'h3, 64'h2000, 64'h1, 1'b0, 64'd0);
      chk("sc_snoop_rd", r_data, 64'd1);

      // Snoop in the LR ack cycle wins
      issue(5'h02, 3'h3, 64'h2000, 64'h0, 1'b1, 64'h2000);
      issue(5'h03, 3'h3, 64'h2000, 64'h1, 1'b0, 64'd0);
      chk("sc_ack_snoop_rd", r_data, 64'd1);

      // Snoop in the next granule leaves the reservation
      issue(5'h02, 3'h3, 64'h2000, 64'h0, 1'b0, 64'd0);
      pulse_snoop(64'h2008);
      issue(5'h03, 3'h3, 64'h2000, 64'h77, 1'b0, 64'd0);
      chk("sc_far_snoop_rd", r_data, 64'd0);
      chk("sc_far_snoop_wdata", wr_data, 64'h77);

      // LR.W sign extension, then kill clears the reservation
      mem[11'h400] = 64'h80000001_00000000;
      issue(5'h02, 3'h2, 64'h2004, 64'h0, 1'b0, 64'd0);
      chk("lr_w_rd", r_data, 64'hFFFFFFFF_80000001);
      @(negedge clk_i); kill_i = 1'b1;
      @(negedge clk_i); kill_i = 1'b0;
      issue(5'h03, 3'h2, 64'h2004, 64'h5, 1'b0, 64'd0);
      chk("sc_kill_rd", r_data, 64'd1);

      issue(5'h02, 3'h3, 64'h2000, 64'h0, 1'b0, 64'd0);
`else
      issue(5'h02, 3'h3, 64'h2000, 64'h0, 1'b0, 64'd0);
      chk("lr_off_flags", {62'd0, r_mis, r_fault}, 64'b01);
      chk("lr_off_lat", r_lat, 1);
`endif

      // Reset while a write is stalled
      stall_wr = 1'b1; p0 = n_rsp;
      mem[11'h307] = 64'h1;
      @(negedge clk_i);
      req_valid_i = 1'b1; req_funct5_i = 5'h00; req_funct3_i = 3'h3;
      req_addr_i = 64'h1838; req_data_i = 64'h1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      for (int k = 0; k < 10 && !mem_we_o; k++) @(negedge clk_i);
      chk("rstw_in_write", {63'd0, mem_we_o}, 64'd1);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("rstw_req_drop", {63'd0, mem_req_o}, 64'd0);
      chk("rstw_sel", {56'd0, mem_sel_o}, 64'd0);
      chk("rstw_ready", {63'd0, req_ready_o}, 64'd0);
      rst_i = 1'b0; stall_wr = 1'b0;
      repeat (4) @(negedge clk_i);
      chk("rstw_no_rsp", n_rsp - p0, 0);
`ifdef WIV_AMO_LRSC_EN
      issue(5'h03, 3'h3, 64'h2000, 64'h9, 1'b0, 64'd0);
      chk("rstw_rsv_gone", r_data, 64'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
